// File: rtl/exec_ctrl.sv
// Execution and program-load controller: turns front-panel controls into CPU step
// enables (manual, slow, fast) and owns the ROM write port while in edit mode.
module exec_ctrl #(
    parameter logic [31:0] SLOW_DIV = 32'd4_000_000,
    parameter logic [31:0] FAST_DIV = 32'd4_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next,
    input  logic        run,
    input  logic        speedRun,
    input  logic        edit,
    input  logic [7:0]  line,
    input  logic [31:0] code,
    input  logic        send,
    input  logic        halt,
    output logic        step_en,
    output logic        rom_we,
    output logic [7:0]  rom_waddr,
    output logic [31:0] rom_wdata,
    output logic        core_hold,
    output logic [2:0]  state,
    output logic [7:0]  load_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EDIT = 3'd1,
        S_RUN  = 3'd2,
        S_FAST = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic        next_prev_q, next_prev_d;
    logic        send_prev_q, send_prev_d;
    logic        step_en_q, step_en_d;
    logic        rom_we_q, rom_we_d;
    logic [7:0]  rom_waddr_q, rom_waddr_d;
    logic [31:0] rom_wdata_q, rom_wdata_d;
    logic        core_hold_q, core_hold_d;
    logic [7:0]  load_count_q, load_count_d;

    logic        next_edge, send_edge, send_fire, running, at_term, stay;
    logic [31:0] div_term;

    assign next_edge = next & ~next_prev_q;
    assign send_edge = send & ~send_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode priority: edit > halt > speedRun > run > next.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (edit)          state_d = S_EDIT;
                else if (halt)     state_d = S_IDLE;
                else if (speedRun) state_d = S_FAST;
                else if (run)      state_d = S_RUN;
            end
            S_EDIT: begin
                if (!edit) state_d = S_IDLE;
            end
            S_RUN: begin
                if (edit)          state_d = S_EDIT;
                else if (halt)     state_d = S_HALT;
                else if (speedRun) state_d = S_FAST;
                else if (!run)     state_d = S_IDLE;
            end
            S_FAST: begin
                if (edit)                state_d = S_EDIT;
                else if (halt)           state_d = S_HALT;
                else if (!speedRun &&  run) state_d = S_RUN;
                else if (!speedRun && !run) state_d = S_IDLE;
            end
            S_HALT: begin
                if (edit)                  state_d = S_EDIT;
                else if (!run && !speedRun) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running     = (state_q == S_RUN) || (state_q == S_FAST);
        div_term    = (state_q == S_FAST) ? (FAST_DIV - 32'd1) : (SLOW_DIV - 32'd1);
        at_term     = (div_q == div_term);
        stay        = (state_d == state_q);
        send_fire   = (state_q == S_EDIT) && edit && send_edge;

        next_prev_d = next;
        send_prev_d = send;

        // A pulse is only issued when the mode is not changing this cycle.
        step_en_d = 1'b0;
        if (state_q == S_IDLE && stay && !halt && next_edge) begin
            step_en_d = 1'b1;
        end
        if (running && stay && at_term) begin
            step_en_d = 1'b1;
        end

        div_d = 32'd0;
        if (running && stay && !at_term) begin
            div_d = div_q + 32'd1;
        end

        rom_we_d    = send_fire;
        rom_waddr_d = send_fire ? line : rom_waddr_q;
        rom_wdata_d = send_fire ? code : rom_wdata_q;

        load_count_d = load_count_q;
        if (state_q != S_EDIT && state_d == S_EDIT) begin
            load_count_d = 8'd0;
        end else if (send_fire && load_count_q != 8'hFF) begin
            load_count_d = load_count_q + 8'd1;
        end

        core_hold_d = (state_d == S_EDIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= 32'd0;
            next_prev_q  <= 1'b0;
            send_prev_q  <= 1'b0;
            step_en_q    <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= 8'd0;
            rom_wdata_q  <= 32'd0;
            core_hold_q  <= 1'b0;
            load_count_q <= 8'd0;
        end else begin
            div_q        <= div_d;
            next_prev_q  <= next_prev_d;
            send_prev_q  <= send_prev_d;
            step_en_q    <= step_en_d;
            rom_we_q     <= rom_we_d;
            rom_waddr_q  <= rom_waddr_d;
            rom_wdata_q  <= rom_wdata_d;
            core_hold_q  <= core_hold_d;
            load_count_q <= load_count_d;
        end
    end

    assign step_en    = step_en_q;
    assign rom_we     = rom_we_q;
    assign rom_waddr  = rom_waddr_q;
    assign rom_wdata  = rom_wdata_q;
    assign core_hold  = core_hold_q;
    assign state      = state_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: a sequential vector table from reset, then
// hand-written sequences for load-count saturation and asynchronous reset mid-run.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        next, run, speedRun, edit, send, halt;
    logic [7:0]  line;
    logic [31:0] code;
    logic        step_en, rom_we, core_hold;
    logic [7:0]  rom_waddr, load_count;
    logic [31:0] rom_wdata;
    logic [2:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    exec_ctrl #(.SLOW_DIV(32'd4), .FAST_DIV(32'd2)) dut (
        .clk(clk), .rst(rst), .next(next), .run(run), .speedRun(speedRun),
        .edit(edit), .line(line), .code(code), .send(send), .halt(halt),
        .step_en(step_en), .rom_we(rom_we), .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata), .core_hold(core_hold), .state(state),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        nx, rn, sr, ed, sd, ht;
        logic [7:0]  ln;
        logic [31:0] cd;
        logic [2:0]  st;
        logic        se, we, ch;
        logic [7:0]  lc, wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic nx, rn, sr, ed, sd, ht,
                       input logic [7:0] ln, input logic [31:0] cd,
                       input logic [2:0] st, input logic se, we, ch,
                       input logic [7:0] lc, wa, input logic [31:0] wd);
        vec_t v;
        v.nx = nx; v.rn = rn; v.sr = sr; v.ed = ed; v.sd = sd; v.ht = ht;
        v.ln = ln; v.cd = cd; v.st = st; v.se = se; v.we = we; v.ch = ch;
        v.lc = lc; v.wa = wa; v.wd = wd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic se, we, ch,
                           input logic [7:0] lc, wa, input logic [31:0] wd);
        chk({tag, " state"},      {29'd0, state}, {29'd0, st});
        chk({tag, " step_en"},    {31'd0, step_en}, {31'd0, se});
        chk({tag, " rom_we"},     {31'd0, rom_we}, {31'd0, we});
        chk({tag, " core_hold"},  {31'd0, core_hold}, {31'd0, ch});
        chk({tag, " load_count"}, {24'd0, load_count}, {24'd0, lc});
        chk({tag, " rom_waddr"},  {24'd0, rom_waddr}, {24'd0, wa});
        chk({tag, " rom_wdata"},  rom_wdata, wd);
    endtask

    initial begin
        int we_seen;
        rst = 1'b0; next = 0; run = 0; speedRun = 0; edit = 0; send = 0; halt = 0;
        line = 8'd0; code = 32'd0;

        //   nx rn sr ed sd ht  line   code           st se we ch lc  wa     wd
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 0, 8'h00, 32'h0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 0, 8'h00, 32'h0);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 8'h00, 32'h0);
        add(0, 0, 0, 1, 0, 0, 8'h00, 32'h0,        1, 0, 0, 1, 0, 8'h00, 32'h0);
        add(0, 0, 0, 1, 1, 0, 8'h00, 32'hDEADBEEF, 1, 0, 1, 1, 1, 8'h00, 32'hDEADBEEF);
        add(0, 0, 0, 1, 1, 0, 8'h01, 32'h12345678, 1, 0, 0, 1, 1, 8'h00, 32'hDEADBEEF);
        add(0, 0, 0, 1, 0, 0, 8'h01, 32'h12345678, 1, 0, 0, 1, 1, 8'h00, 32'hDEADBEEF);
        add(0, 0, 0, 1, 1, 0, 8'h01, 32'h12345678, 1, 0, 1, 1, 2, 8'h01, 32'h12345678);
        add(1, 1, 0, 1, 0, 0, 8'h01, 32'h12345678, 1, 0, 0, 1, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 1, 0, 8'h77, 32'hCAFEF00D, 0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(1, 1, 0, 0, 0, 0, 8'h00, 32'h0,        2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,    2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        2, 1, 0, 0, 2, 8'h01, 32'h12345678);
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,    2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        2, 1, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 1, 0, 0, 0, 8'h00, 32'h0,        3, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 1, 0, 0, 0, 8'h00, 32'h0,        3, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 1, 0, 0, 0, 8'h00, 32'h0,        3, 1, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 1, 0, 0, 0, 8'h00, 32'h0,        3, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 1, 0, 0, 0, 8'h00, 32'h0,        3, 1, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        for (int k = 0; k < 4; k++)
            add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,    2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 0, 0, 1, 8'h00, 32'h0,        4, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 0, 0, 1, 8'h00, 32'h0,        4, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 1, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(1, 0, 0, 0, 0, 1, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 1, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 1, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 2, 8'h01, 32'h12345678);
        for (int k = 0; k < 4; k++)
            add(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,    2, 0, 0, 0, 2, 8'h01, 32'h12345678);
        add(0, 1, 0, 1, 0, 0, 8'h00, 32'h0,        1, 0, 0, 1, 0, 8'h01, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 8'h01, 32'h12345678);

        // Reset held across clock edges.
        step();
        step();
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
        rst = 1'b1;

        foreach (vq[i]) begin
            next = vq[i].nx; run = vq[i].rn; speedRun = vq[i].sr;
            edit = vq[i].ed; send = vq[i].sd; halt = vq[i].ht;
            line = vq[i].ln; code = vq[i].cd;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].se, vq[i].we, vq[i].ch,
                    vq[i].lc, vq[i].wa, vq[i].wd);
        end

        // Load-count saturation over 300 sends.
        edit = 1'b1; send = 1'b0; next = 0; run = 0; speedRun = 0; halt = 0;
        step();
        chk("sat enter state", {29'd0, state}, 32'd1);
        we_seen = 0;
        for (int i = 0; i < 300; i++) begin
            line = i[7:0];
            code = i;
            send = 1'b1;
            step();
            if (rom_we === 1'b1) we_seen++;
            if (step_en !== 1'b0) chk("sat step_en", {31'd0, step_en}, 32'd0);
            if (i == 253) chk("sat lc 254", {24'd0, load_count}, 32'd254);
            if (i == 254) chk("sat lc 255", {24'd0, load_count}, 32'd255);
            send = 1'b0;
            step();
        end
        chk("sat we pulses", we_seen, 32'd300);
        chk("sat lc final", {24'd0, load_count}, 32'd255);
        chk("sat waddr", {24'd0, rom_waddr}, 32'h2B);
        chk("sat wdata", rom_wdata, 32'd299);
        chk("sat core_hold", {31'd0, core_hold}, 32'd1);

        // Asynchronous reset right after a RUN pulse.
        edit = 1'b0;
        step();
        chk("pre-run state", {29'd0, state}, 32'd0);
        run = 1'b1;
        step();
        step();
        step();
        step();
        chk("pre-reset div3 step_en", {31'd0, step_en}, 32'd0);
        step();
        chk("pre-reset step_en", {31'd0, step_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk_all("async reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
        run = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post-reset%0d step_en", k), {31'd0, step_en}, 32'd0);
            chk($sformatf("post-reset%0d state", k), {29'd0, state}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
